mpmc10_rd_strip_gather: RTL

Collects the read-data strips returned by the DDR app interface for one multi-strip burst and assembles them into a full line for the requesting channel. Sits directly downstream of the controller's read address issue. Its strip counter is exported to the controller state machine and the address generator, so address advance and data capture stay in lock-step. Holds the assembled line until the consumer acknowledges it.

---
 rtl/mpmc10_pkg.sv | 22 ++
 rtl/mpmc10_rd_strip_gather_if.sv | 40 ++++
 rtl/mpmc10_rd_strip_gather.sv | 113 +++++++++++
 3 files changed

// File: rtl/mpmc10_pkg.sv
// Shared types and constants for the mpmc10 controller.
// Holds the read strip gather state encoding and line geometry.
package mpmc10_pkg;

  localparam int MPMC10_STRIP_W    = 128;
  localparam int MPMC10_MAX_STRIPS = 4;
  localparam int MPMC10_CNT_W      = 6;

  typedef enum logic [1:0] {
    RDG_IDLE,
    RDG_COLLECT,
    RDG_DONE
  } mpmc10_rdg_state_t;

  function automatic logic [MPMC10_CNT_W-1:0] rdg_clamp(
    input logic [MPMC10_CNT_W-1:0] n,
    input logic [MPMC10_CNT_W-1:0] lim
  );
    return (n > lim) ? lim : n;
  endfunction

endpackage

// File: rtl/mpmc10_rd_strip_gather_if.sv
// Bundle between read issue, app read data, gather block and consumer.
// slave = gather block, master = the surrounding controller.
interface mpmc10_rd_strip_gather_if
  import mpmc10_pkg::*;
#(
  parameter int STRIP_W    = MPMC10_STRIP_W,
  parameter int MAX_STRIPS = MPMC10_MAX_STRIPS,
  parameter int TAG_W      = 4
) ();

  logic                          start;
  logic [MPMC10_CNT_W-1:0]       num_strips;
  logic [TAG_W-1:0]              tag_i;
  logic                          rd_data_valid;
  logic [STRIP_W-1:0]            rd_data;
  logic                          line_ack;
  logic [MPMC10_CNT_W-1:0]       strip_cnt;
  logic                          busy;
  logic                          line_valid;
  logic [MAX_STRIPS*STRIP_W-1:0] line_o;
  logic [TAG_W-1:0]              tag_o;
  logic                          err_overrun;

  modport slave (
    input  start, num_strips, tag_i,
    input  rd_data_valid, rd_data,
    input  line_ack,
    output strip_cnt, busy, line_valid,
    output line_o, tag_o, err_overrun
  );

  modport master (
    output start, num_strips, tag_i,
    output rd_data_valid, rd_data,
    output line_ack,
    input  strip_cnt, busy, line_valid,
    input  line_o, tag_o, err_overrun
  );

endinterface

// File: rtl/mpmc10_rd_strip_gather.sv
// Gathers app read-data strips of one burst into a full line
// and holds it, with its tag, until the consumer acknowledges.
module mpmc10_rd_strip_gather
  import mpmc10_pkg::*;
#(
  parameter int STRIP_W    = MPMC10_STRIP_W,
  parameter int MAX_STRIPS = MPMC10_MAX_STRIPS,
  parameter int TAG_W      = 4
) (
  input logic clk,
  input logic rst,
  mpmc10_rd_strip_gather_if.slave bus
);

  localparam int LINE_W = MAX_STRIPS * STRIP_W;
  localparam logic [MPMC10_CNT_W-1:0] LAST_MAX =
    MPMC10_CNT_W'(MAX_STRIPS - 1);

  mpmc10_rdg_state_t state_q, state_d;

  logic [MPMC10_CNT_W-1:0] last_q;
  logic [MPMC10_CNT_W-1:0] cnt_q;
  logic [LINE_W-1:0]       line_q;
  logic [TAG_W-1:0]        tag_q;
  logic                    lv_q;
  logic                    err_q;

  logic take;
  logic cap;
  logic is_last;
  logic stray;

  always_comb begin
    take    = 1'b0;
    cap     = 1'b0;
    stray   = 1'b0;
    is_last = (cnt_q == last_q);
    unique case (state_q)
      RDG_IDLE: begin
        take  = bus.start;
        stray = bus.rd_data_valid && !bus.start;
      end
      RDG_COLLECT: begin
        cap = bus.rd_data_valid;
      end
      RDG_DONE: begin
        take  = bus.start && bus.line_ack;
        stray = bus.rd_data_valid;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RDG_IDLE:
        if (bus.start) state_d = RDG_COLLECT;
      RDG_COLLECT:
        if (cap && is_last) state_d = RDG_DONE;
      RDG_DONE:
        if (bus.line_ack)
          state_d = bus.start ? RDG_COLLECT : RDG_IDLE;
      default:
        state_d = RDG_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= RDG_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= '0;
      cnt_q  <= '0;
      line_q <= '0;
      tag_q  <= '0;
      lv_q   <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      if (take) begin
        last_q <= rdg_clamp(bus.num_strips, LAST_MAX);
        tag_q  <= bus.tag_i;
        cnt_q  <= '0;
        line_q <= '0;
        err_q  <= 1'b0;
      end
      if (cap) begin
        for (int i = 0; i < MAX_STRIPS; i++) begin
          if (cnt_q == MPMC10_CNT_W'(i))
            line_q[i*STRIP_W +: STRIP_W] <= bus.rd_data;
        end
        if (is_last) lv_q  <= 1'b1;
        else         cnt_q <= cnt_q + 1'b1;
      end
      if (state_q == RDG_DONE && bus.line_ack)
        lv_q <= 1'b0;
      // A beat nobody asked for is flagged, never stored
      if (stray)
        err_q <= 1'b1;
    end
  end

  assign bus.strip_cnt   = cnt_q;
  assign bus.busy        = (state_q != RDG_IDLE);
  assign bus.line_valid  = lv_q;
  assign bus.line_o      = line_q;
  assign bus.tag_o       = tag_q;
  assign bus.err_overrun = err_q;

endmodule
